vector_list_sequencer: RTL and testbench
========================================

# vector_list_sequencer

Frame-level sequencer for the vector image ROM. On each frame start it walks a list of up to NOBJ display objects (map, frame, cursor, plane, …): it drives the ROM address, decodes each 18-bit entry, applies a per-object x/y offset, and hands vectors one at a time to the downstream line drawer over a valid/ready handshake. It sits between the frame timing logic and the beam/line-draw datapath, and is the only ROM address master.

## Interface
Parameters:
- ADDRESSWIDTH, 16, ROM address width
- DATAWIDTH, 18, ROM word width, {x[7:0], y[7:0], line, pos}
- NOBJ, 4, number of object slots
- MAXLEN, 64, maximum entries fetched per object before a forced abort

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse; begins a frame pass when idle
- obj_en  in  NOBJ  per-slot enable, sampled at frame_start
- obj_base  in  NOBJ*ADDRESSWIDTH  slot i base address at bits [i*ADDRESSWIDTH +: ADDRESSWIDTH], sampled at frame_start
- obj_dx, obj_dy  in  NOBJ*8 each  per-slot offset, sampled at frame_start
- rom_addr  out  ADDRESSWIDTH  registered ROM address
- rom_data  in  DATAWIDTH  ROM output, combinational from rom_addr
- vec_x, vec_y  out  8 each  vector endpoint after offset
- vec_line  out  1  1 = draw to point, 0 = move (beam off)
- vec_obj  out  $clog2(NOBJ)  source slot of current vector
- vec_valid  out  1  vector available
- vec_ready  in  1  downstream accepts
- busy  out  1  frame pass in progress
- frame_done  out  1  one-cycle pulse at end of pass
- err_overrun  out  1  sticky; a slot hit MAXLEN without terminator; cleared only by reset

## Operation
- States: IDLE, SCAN, FETCH, EMIT.
- IDLE: busy=0. frame_start=1 → latch obj_en/obj_base/obj_dx/obj_dy into shadow registers, set slot=0, go to SCAN.
- SCAN: find the lowest enabled slot ≥ slot. If one is found, set rom_addr to its base, set the entry counter cnt to 0, and go to FETCH. If none remain, pulse frame_done and go to IDLE.
- FETCH: decode rom_data.
  - Terminator (line=1 and pos=1): never emitted. slot+1, go to SCAN.
  - Otherwise, register:
    - vec_x = x+dx mod 256
    - vec_y = y+dy mod 256 (wrap, no saturation)
    - vec_line = line
    - vec_obj = slot
  - Then set vec_valid=1 and go to EMIT.
- EMIT: hold all vec_* stable while vec_valid & !vec_ready. On vec_valid & vec_ready:
  - vec_valid=0, rom_addr+1 (wraps mod 2^ADDRESSWIDTH), cnt+1.
  - If cnt+1 == MAXLEN: set err_overrun, slot+1, go to SCAN.
  - Otherwise go to FETCH.
- pos is informational only; a move entry is identified solely by line=0.
- frame_start while busy is ignored; there is no queuing.
- Live input changes during a pass have no effect; only the shadow copies are used.
- obj_en all zero → IDLE → SCAN → frame_done, with no vectors emitted.

## Timing
- Reset values:
  - state=IDLE
  - rom_addr=0, vec_x=0, vec_y=0, vec_line=0, vec_obj=0
  - vec_valid=0, busy=0, frame_done=0, err_overrun=0
- busy=1 from the cycle after frame_start is accepted through the cycle in which frame_done pulses.
- Latency: with frame_start sampled at edge E, rom_addr equals the first base after E+1 and vec_valid rises after E+2.
- Throughput: one vector per 2 cycles with vec_ready held high (FETCH + EMIT).
- Each terminator costs one FETCH cycle plus one SCAN cycle.
- frame_done is high for exactly one cycle and coincides with busy's last cycle. busy=0 the following cycle.
- Handshake: vec_valid, once asserted, drops only after a transfer, never spontaneously. vec_ready may be high while vec_valid=0 without effect.
- Asynchronous rst_n assertion mid-pass returns all outputs to reset values immediately. Any in-flight vector is discarded and not replayed.

## Test plan
- Frame object: base=42, only slot 0 enabled, offsets 0, vec_ready=1 → exactly 5 vectors: (0,255,L0), (0,0,L1), (255,0,L1), (255,255,L1), (0,255,L1). Then frame_done pulses; entry 47 is never emitted.
- Cursor with offset: base=48, dx=250, dy=10 → first vector (16,60,L0) (wrap 22+250), then (40,56,L1). 5 vectors total; vec_obj=0.
- Multi-slot ordering:
  - Setup: slots 0–3 bases = 0, 42, 48, 54, with obj_en=4'b1010.
  - Required: only the frame vectors (vec_obj=1), then the plane vectors (vec_obj=3). Plane yields 17 vectors.
  - Required: frame_done follows the last plane vector.
- Backpressure: vec_ready toggles randomly. Every vector is held stable until accepted, none is dropped or duplicated, and the sequence equals the vec_ready=1 sequence.
- Overrun: MAXLEN=4 on a list longer than 4 → 4 vectors emitted, err_overrun=1 and stays set. The next slot still runs; a new frame_start works with err_overrun still 1.
- Control corners:
  - frame_start pulsed mid-pass → ignored, single frame_done.
  - obj_en=0 → frame_done 2 cycles after frame_start, with no vec_valid.
  - rst_n asserted during EMIT → vec_valid=0 and busy=0 immediately.

Source files
------------

// File: rtl/vector_list_sequencer_if.sv
// Vector hand-off bus from the list sequencer to the line drawer.
// Endpoint, draw/move flag and source slot travel with a valid/ready pair.
interface vector_list_sequencer_if #(
  parameter int NOBJ = 4
);
  localparam int OW = (NOBJ > 1) ? $clog2(NOBJ) : 1;

  logic [7:0]    vec_x;
  logic [7:0]    vec_y;
  logic          vec_line;
  logic [OW-1:0] vec_obj;
  logic          vec_valid;
  logic          vec_ready;

  modport master (output vec_x, vec_y, vec_line, vec_obj, vec_valid, input vec_ready);
  modport slave  (input vec_x, vec_y, vec_line, vec_obj, vec_valid, output vec_ready);
endinterface

// File: rtl/vector_list_sequencer.sv
// Per-frame walker over the enabled object lists in the vector ROM; decodes
// entries, applies per-slot offsets and hands vectors to the line drawer.
module vector_list_sequencer #(
  parameter int ADDRESSWIDTH = 16,
  parameter int DATAWIDTH    = 18,
  parameter int NOBJ         = 4,
  parameter int MAXLEN       = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         frame_start,
  input  logic [NOBJ-1:0]              obj_en,
  input  logic [NOBJ*ADDRESSWIDTH-1:0] obj_base,
  input  logic [NOBJ*8-1:0]            obj_dx,
  input  logic [NOBJ*8-1:0]            obj_dy,
  output logic [ADDRESSWIDTH-1:0]      rom_addr,
  input  logic [DATAWIDTH-1:0]         rom_data,
  vector_list_sequencer_if.master      vec,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         err_overrun
);
  localparam int OW = (NOBJ > 1) ? $clog2(NOBJ) : 1;
  localparam int SW = OW + 1;
  localparam int CW = $clog2(MAXLEN + 1);

  typedef enum logic [1:0] {IDLE, SCAN, FETCH, EMIT} state_t;
  state_t state, state_nx;

  logic [NOBJ-1:0]              en_sh;
  logic [NOBJ*ADDRESSWIDTH-1:0] base_sh;
  logic [NOBJ*8-1:0]            dx_sh, dy_sh;
  logic [SW-1:0]                slot;
  logic [CW-1:0]                cnt, cnt_inc;
  logic                         found;
  logic [OW-1:0]                hit, cur;
  logic [7:0]                   ent_x, ent_y;
  logic                         ent_line, ent_term, xfer, accept, last;

  assign ent_x    = rom_data[DATAWIDTH-1 -: 8];
  assign ent_y    = rom_data[DATAWIDTH-9 -: 8];
  assign ent_line = rom_data[1];
  assign ent_term = rom_data[1] & rom_data[0];
  assign cur      = slot[OW-1:0];
  assign cnt_inc  = cnt + 1'b1;
  assign last     = (cnt_inc == CW'(MAXLEN));
  assign xfer     = vec.vec_valid & vec.vec_ready;
  // busy is still high during the frame_done cycle, so a start there is dropped
  assign accept   = frame_start & ~busy;

  // Lowest enabled slot at or above the current one; slot may run to NOBJ.
  always_comb begin
    found = 1'b0;
    hit   = '0;
    for (int i = NOBJ-1; i >= 0; i--)
      if (en_sh[i] && (SW'(i) >= slot)) begin
        found = 1'b1;
        hit   = OW'(i);
      end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept) state_nx = SCAN;
      SCAN:  state_nx = found ? FETCH : IDLE;
      FETCH: state_nx = ent_term ? SCAN : EMIT;
      EMIT:  if (xfer) state_nx = last ? SCAN : FETCH;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_sh         <= '0;
      base_sh       <= '0;
      dx_sh         <= '0;
      dy_sh         <= '0;
      slot          <= '0;
      cnt           <= '0;
      rom_addr      <= '0;
      vec.vec_x     <= '0;
      vec.vec_y     <= '0;
      vec.vec_line  <= 1'b0;
      vec.vec_obj   <= '0;
      vec.vec_valid <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      err_overrun   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= accept;
          if (accept) begin
            en_sh   <= obj_en;
            base_sh <= obj_base;
            dx_sh   <= obj_dx;
            dy_sh   <= obj_dy;
            slot    <= '0;
          end
        end
        SCAN: begin
          if (found) begin
            slot     <= SW'(hit);
            rom_addr <= base_sh[hit*ADDRESSWIDTH +: ADDRESSWIDTH];
            cnt      <= '0;
          end else begin
            frame_done <= 1'b1;
          end
        end
        FETCH: begin
          if (ent_term) begin
            slot <= slot + 1'b1;
          end else begin
            vec.vec_x     <= ent_x + dx_sh[cur*8 +: 8];
            vec.vec_y     <= ent_y + dy_sh[cur*8 +: 8];
            vec.vec_line  <= ent_line;
            vec.vec_obj   <= cur;
            vec.vec_valid <= 1'b1;
          end
        end
        EMIT: begin
          if (xfer) begin
            vec.vec_valid <= 1'b0;
            rom_addr      <= rom_addr + 1'b1;
            cnt           <= cnt_inc;
            if (last) begin
              err_overrun <= 1'b1;
              slot        <= slot + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_list_sequencer.sv
// Directed bench: a full-length sequencer and a MAXLEN=4 copy on a shared ROM image.
module tb_vector_list_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fs0 = 1'b0, fs1 = 1'b0;
  logic [3:0]  obj_en = '0;
  logic [63:0] obj_base = '0;
  logic [31:0] obj_dx = '0, obj_dy = '0;
  logic [15:0] rom_addr0, rom_addr1;
  logic [17:0] rom_data0, rom_data1;
  logic        busy0, busy1, fdone0, fdone1, err0, err1;

  vector_list_sequencer_if #(.NOBJ(4)) vif0 ();
  vector_list_sequencer_if #(.NOBJ(4)) vif1 ();

  always #5 clk = ~clk;

  function automatic logic [17:0] ent(input int x, input int y, input int l, input int p);
    return {8'(x), 8'(y), 1'(l), 1'(p)};
  endfunction

  // ROM image: map@0, frame@42, cursor@48, plane@54 (17 entries), each terminated.
  function automatic logic [17:0] rom_word(input logic [15:0] a);
    int i;
    rom_word = ent(8'hAA, 8'h55, 0, 0);
    case (a)
      16'd0:  rom_word = ent(10, 20, 0, 1);
      16'd1:  rom_word = ent(30, 20, 1, 0);
      16'd2:  rom_word = ent(30, 40, 1, 0);
      16'd42: rom_word = ent(0, 255, 0, 0);
      16'd43: rom_word = ent(0, 0, 1, 0);
      16'd44: rom_word = ent(255, 0, 1, 0);
      16'd45: rom_word = ent(255, 255, 1, 0);
      16'd46: rom_word = ent(0, 255, 1, 0);
      16'd48: rom_word = ent(22, 50, 0, 0);
      16'd49: rom_word = ent(46, 46, 1, 0);
      16'd50: rom_word = ent(46, 54, 1, 0);
      16'd51: rom_word = ent(22, 58, 1, 0);
      16'd52: rom_word = ent(22, 50, 1, 0);
      16'd3, 16'd47, 16'd53, 16'd71: rom_word = ent(0, 0, 1, 1);
      default: ;
    endcase
    if (a >= 16'd54 && a <= 16'd70) begin
      i = int'(a) - 54;
      rom_word = ent(100 + 4*i, 200 - 3*i, (i == 0 || i == 8) ? 0 : 1, 0);
    end
  endfunction

  assign rom_data0 = rom_word(rom_addr0);
  assign rom_data1 = rom_word(rom_addr1);

  vector_list_sequencer #(.MAXLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(fs0), .obj_en(obj_en), .obj_base(obj_base),
    .obj_dx(obj_dx), .obj_dy(obj_dy), .rom_addr(rom_addr0), .rom_data(rom_data0),
    .vec(vif0.master), .busy(busy0), .frame_done(fdone0), .err_overrun(err0));

  vector_list_sequencer #(.MAXLEN(4)) dut_ov (
    .clk(clk), .rst_n(rst_n), .frame_start(fs1), .obj_en(obj_en), .obj_base(obj_base),
    .obj_dx(obj_dx), .obj_dy(obj_dy), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .vec(vif1.master), .busy(busy1), .frame_done(fdone1), .err_overrun(err1));

  int total = 0, bad = 0;
  int fd0 = 0, fd1 = 0, vseen0 = 0, hold_err = 0, fdbad = 0;
  logic [18:0] q0[$], q1[$], ex[$];
  logic [18:0] cur0, cur1, hold0, hold1;
  logic        st0 = 1'b0, st1 = 1'b0, pfd0 = 1'b0, pfd1 = 1'b0;

  assign cur0 = {vif0.vec_obj, vif0.vec_line, vif0.vec_x, vif0.vec_y};
  assign cur1 = {vif1.vec_obj, vif1.vec_line, vif1.vec_x, vif1.vec_y};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transfers, stall stability and frame_done shape observed mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      st0 <= 1'b0; st1 <= 1'b0; pfd0 <= 1'b0; pfd1 <= 1'b0;
    end else begin
      if (vif0.vec_valid && vif0.vec_ready) q0.push_back(cur0);
      if (vif1.vec_valid && vif1.vec_ready) q1.push_back(cur1);
      if ((st0 && (!vif0.vec_valid || cur0 != hold0)) || (st1 && (!vif1.vec_valid || cur1 != hold1)))
        hold_err <= hold_err + 1;
      st0 <= vif0.vec_valid && !vif0.vec_ready; hold0 <= cur0;
      st1 <= vif1.vec_valid && !vif1.vec_ready; hold1 <= cur1;
      if (vif0.vec_valid) vseen0 <= vseen0 + 1;
      if (fdone0) fd0 <= fd0 + 1;
      if (fdone1) fd1 <= fd1 + 1;
      if ((fdone0 && !busy0) || (fdone1 && !busy1) || (pfd0 && busy0) || (pfd1 && busy1))
        fdbad <= fdbad + 1;
      pfd0 <= fdone0; pfd1 <= fdone1;
    end
  end

  function automatic logic [18:0] pk(input int o, input int l, input int x, input int y);
    return {2'(o), 1'(l), 8'(x), 8'(y)};
  endfunction

  task automatic ex_frame(input int o);
    ex.push_back(pk(o, 0, 0, 255));   ex.push_back(pk(o, 1, 0, 0));
    ex.push_back(pk(o, 1, 255, 0));   ex.push_back(pk(o, 1, 255, 255));
    ex.push_back(pk(o, 1, 0, 255));
  endtask

  task automatic ex_plane(input int o, input int n);
    for (int i = 0; i < n; i++)
      ex.push_back(pk(o, (i == 0 || i == 8) ? 0 : 1, 100 + 4*i, 200 - 3*i));
  endtask

  task automatic ex_map(input int o);
    ex.push_back(pk(o, 0, 10, 20)); ex.push_back(pk(o, 1, 30, 20)); ex.push_back(pk(o, 1, 30, 40));
  endtask

  task automatic cmp(input int which, input string tag);
    int n;
    logic [18:0] g;
    n = which ? q1.size() : q0.size();
    chk({tag, "_len"}, n, ex.size());
    for (int i = 0; i < n && i < ex.size(); i++) begin
      g = which ? q1[i] : q0[i];
      chk(tag, {13'd0, g}, {13'd0, ex[i]});
    end
  endtask

  // One frame pass on the chosen DUT; waits for frame_done within a cycle budget.
  task automatic go(input int which, input bit rnd, input bit mid, input int lat_base);
    int f, n;
    f = which ? fd1 : fd0;
    if (which) q1.delete(); else q0.delete();
    @(posedge clk); #1;
    if (which) fs1 = 1'b1; else fs0 = 1'b1;
    @(posedge clk); #1;
    fs0 = 1'b0; fs1 = 1'b0;
    if (lat_base >= 0) chk("lat_busy", busy0, 1);
    for (int i = 0; i < 3000 && (which ? fd1 : fd0) == f; i++) begin
      @(posedge clk); #1;
      if (lat_base >= 0 && i == 0) begin
        chk("lat_addr", rom_addr0, lat_base);
        chk("lat_vld0", vif0.vec_valid, 0);
      end
      if (lat_base >= 0 && i == 1) begin
        chk("lat_vld1", vif0.vec_valid, 1);
        chk("lat_y", vif0.vec_y, 255);
      end
      if (rnd) vif0.vec_ready = 1'($urandom_range(0, 1));
      fs0 = mid && (i == 6);
      if (mid && i == 3) begin
        obj_en = '1; obj_base = '0; obj_dx = '1; obj_dy = '1;
      end
    end
    vif0.vec_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n = which ? fd1 : fd0;
    chk("done_cnt", n - f, 1);
  endtask

  initial begin
    int v, f;
    vif0.vec_ready = 1'b1;
    vif1.vec_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", rom_addr0, 0);
    chk("rst_vld", vif0.vec_valid, 0);
    chk("rst_vec", {vif0.vec_obj, vif0.vec_line, vif0.vec_x, vif0.vec_y}, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_fd", fdone0, 0);
    chk("rst_err", {err0, err1}, 0);
    rst_n = 1'b1;

    // single frame object, latency probe
    obj_en = 4'b0001; obj_base = 64'd42;
    go(0, 0, 0, 42);
    ex.delete(); ex_frame(0); cmp(0, "frame");
    chk("frame_busy_off", busy0, 0);

    // cursor with wrapping offset
    obj_en = 4'b0001; obj_base = 64'd48; obj_dx = 32'd250; obj_dy = 32'd10;
    go(0, 0, 0, -1);
    ex.delete();
    ex.push_back(pk(0, 0, 16, 60)); ex.push_back(pk(0, 1, 40, 56)); ex.push_back(pk(0, 1, 40, 64));
    ex.push_back(pk(0, 1, 16, 68)); ex.push_back(pk(0, 1, 16, 60));
    cmp(0, "cursor");

    // multi-slot ordering, with a mid-pass start pulse and live input changes
    obj_en = 4'b1010; obj_base = {16'd54, 16'd48, 16'd42, 16'd0}; obj_dx = '0; obj_dy = '0;
    go(0, 0, 1, -1);
    ex.delete(); ex_frame(1); ex_plane(3, 17); cmp(0, "multi");

    // same frame under random backpressure
    obj_en = 4'b1010; obj_base = {16'd54, 16'd48, 16'd42, 16'd0}; obj_dx = '0; obj_dy = '0;
    go(0, 1, 0, -1);
    cmp(0, "bp");

    // no slots enabled
    obj_en = 4'b0000; v = vseen0;
    @(posedge clk); #1 fs0 = 1'b1;
    @(posedge clk); #1 fs0 = 1'b0;
    chk("z_busy", busy0, 1); chk("z_fd_early", fdone0, 0);
    @(posedge clk); #1;
    chk("z_fd", fdone0, 1); chk("z_busy_last", busy0, 1);
    @(posedge clk); #1;
    chk("z_fd_off", fdone0, 0); chk("z_idle", busy0, 0); chk("z_novec", vseen0 - v, 0);

    // overrun on the MAXLEN=4 copy: slot 0 truncated, slot 1 still runs
    obj_en = 4'b0011; obj_base = {16'd0, 16'd0, 16'd0, 16'd54}; obj_dx = '0; obj_dy = '0;
    chk("ov_err_pre", err1, 0);
    go(1, 0, 0, -1);
    ex.delete(); ex_plane(0, 4); ex_map(1); cmp(1, "ov");
    chk("ov_err", err1, 1);
    go(1, 0, 0, -1);
    cmp(1, "ov2");
    chk("ov_err_sticky", err1, 1);

    // reset while a vector is stalled in EMIT
    obj_en = 4'b0001; obj_base = 64'd42; vif0.vec_ready = 1'b0;
    @(posedge clk); #1 fs0 = 1'b1;
    @(posedge clk); #1 fs0 = 1'b0;
    for (int i = 0; i < 20 && !vif0.vec_valid; i++) begin @(posedge clk); #1; end
    chk("stall_vld", vif0.vec_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", vif0.vec_valid, 0);
    chk("arst_busy", busy0, 0);
    chk("arst_addr", rom_addr0, 0);
    chk("arst_err", err1, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    vif0.vec_ready = 1'b1;
    go(0, 0, 0, -1);
    ex.delete(); ex_frame(0); cmp(0, "post_rst");

    chk("hold", hold_err, 0);
    chk("fd_shape", fdbad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
